sdram_controller: RTL and testbench

//   Single-word controller for two MT48LC16M16A2 x16 SDRAMs wired in parallel as one 32-bit device.

---
 rtl/sdram_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_controller.sv
// sdram_controller: single-word controller for two x16 SDRAMs wired as one 32-bit device.
// Define SDRAM_REFRESH_EN to enable periodic auto-refresh; init refreshes are always issued.
module sdram_controller #(
    parameter int INIT_WAIT_CYCLES = 10000,
    parameter int REFRESH_INTERVAL = 380,
    parameter int CAS_LATENCY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sdc_addr,
    input  logic [31:0] sdc_data,
    input  logic        sdc_we,
    input  logic        sdc_start,
    output logic [31:0] sdc_q,
    output logic        sdc_done,
    output logic        SDRAM_CKE,
    output logic        SDRAM_CSn,
    output logic        SDRAM_WEn,
    output logic        SDRAM_CASn,
    output logic        SDRAM_RASn,
    output logic [12:0] SDRAM_A,
    output logic [1:0]  SDRAM_BA,
    output logic [3:0]  SDRAM_DQM,
    inout  wire  [31:0] SDRAM_DQ
);

    // One counter width serves both the init wait and the refresh interval.
    localparam int W_INIT = $clog2(INIT_WAIT_CYCLES + 1);
    localparam int W_REF  = $clog2(REFRESH_INTERVAL + 1);
    localparam int W_MAX  = (W_INIT > W_REF) ? W_INIT : W_REF;
    localparam int CW     = (W_MAX < 4) ? 4 : W_MAX;

    // {CSn, RASn, CASn, WEn}
    localparam logic [3:0] CMD_DESL  = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [12:0] MODE_REG   = 13'(CAS_LATENCY * 16);
    localparam int          SAMPLE_CYC = 3 + CAS_LATENCY;

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_INIT_SEQ,
        S_IDLE,
        S_ACCESS,
        S_REFRESH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cmd_d;
    logic [12:0]   a_d;
    logic [1:0]    ba_d;
    logic [3:0]    dqm_d;
    logic          dq_oe_q, dq_oe_d;
    logic [31:0]   dq_out_q, dq_out_d;
    logic [31:0]   q_d;
    logic          done_d;
    logic          release_q, release_d;
    logic          accept;
    logic [10:0]   addr_q;
    logic [31:0]   data_q;
    logic          we_q;
    logic          refresh_due;

    assign SDRAM_DQ = dq_oe_q ? dq_out_q : 'z;

`ifdef SDRAM_REFRESH_EN
    logic [CW-1:0] rcnt_q;

    // Due one cycle early so the REF lands exactly REFRESH_INTERVAL edges after the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rcnt_q <= CW'(REFRESH_INTERVAL);
        else if (cmd_d == CMD_REF)
            rcnt_q <= CW'(REFRESH_INTERVAL);
        else if (rcnt_q != '0)
            rcnt_q <= rcnt_q - CW'(1);
    end

    assign refresh_due = (rcnt_q <= CW'(1));
`else
    assign refresh_due = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = CMD_NOP;
        a_d       = '0;
        ba_d      = '0;
        dqm_d     = '1;
        dq_oe_d   = 1'b0;
        dq_out_d  = dq_out_q;
        q_d       = sdc_q;
        done_d    = 1'b0;
        release_d = sdc_start ? release_q : 1'b0;
        accept    = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == CW'(INIT_WAIT_CYCLES)) begin
                    cmd_d   = CMD_PRE;
                    a_d     = 13'h0400;
                    state_d = S_INIT_SEQ;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // Steps: 0 PRE, 1 NOP, 2 REF, 3-5 NOP, 6 REF, 7-9 NOP, 10 MRS, 11-12 NOP.
            S_INIT_SEQ: begin
                cnt_d = cnt_q + CW'(1);
                case (cnt_q)
                    CW'(2), CW'(6): cmd_d = CMD_REF;
                    CW'(10): begin
                        cmd_d = CMD_MRS;
                        a_d   = MODE_REG;
                    end
                    CW'(12): begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
            end
            S_IDLE: begin
                cmd_d = CMD_DESL;
                if (refresh_due) begin
                    cmd_d   = CMD_REF;
                    state_d = S_REFRESH;
                    cnt_d   = CW'(1);
                end else if (sdc_start && !release_q) begin
                    accept  = 1'b1;
                    cmd_d   = CMD_ACT;
                    a_d     = sdc_addr[23:11];
                    ba_d    = sdc_addr[10:9];
                    state_d = S_ACCESS;
                    cnt_d   = CW'(1);
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(2)) begin
                    cmd_d = we_q ? CMD_WRITE : CMD_READ;
                    a_d   = {2'b00, 1'b1, 1'b0, addr_q[8:0]};
                    ba_d  = addr_q[10:9];
                    dqm_d = '0;
                    if (we_q) begin
                        dq_oe_d  = 1'b1;
                        dq_out_d = data_q;
                    end
                end
                if (!we_q && cnt_q == CW'(SAMPLE_CYC))
                    q_d = SDRAM_DQ;
                if (cnt_q == CW'(6)) begin
                    done_d    = 1'b1;
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end
            end
            S_REFRESH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(3)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT_WAIT;
            cnt_q     <= '0;
            SDRAM_CKE <= 1'b1;
            {SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn} <= CMD_DESL;
            SDRAM_A   <= '0;
            SDRAM_BA  <= '0;
            SDRAM_DQM <= '1;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= '0;
            sdc_q     <= '0;
            sdc_done  <= 1'b0;
            release_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            SDRAM_CKE <= 1'b1;
            {SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn} <= cmd_d;
            SDRAM_A   <= a_d;
            SDRAM_BA  <= ba_d;
            SDRAM_DQM <= dqm_d;
            dq_oe_q   <= dq_oe_d;
            dq_out_q  <= dq_out_d;
            sdc_q     <= q_d;
            sdc_done  <= done_d;
            release_q <= release_d;
            if (accept) begin
                addr_q <= sdc_addr[10:0];
                data_q <= sdc_data;
                we_q   <= sdc_we;
            end
        end
    end

endmodule

// File: tb/tb_sdram_controller.sv
// Bench for sdram_controller: behavioural SDRAM pair model plus directed per-feature checks.
`timescale 1ns/1ps
module tb_sdram_controller;

    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sdc_addr;
    logic [31:0] sdc_data;
    logic        sdc_we, sdc_start;
    logic [31:0] sdc_q;
    logic        sdc_done;
    logic        SDRAM_CKE, SDRAM_CSn, SDRAM_WEn, SDRAM_CASn, SDRAM_RASn;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic [3:0]  SDRAM_DQM;
    wire  [31:0] SDRAM_DQ;
    logic [3:0]  cmd;

    int total = 0;
    int bad   = 0;

    assign cmd = {SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn};

    always #5 clk = ~clk;

    sdram_controller #(
        .INIT_WAIT_CYCLES(50),
        .REFRESH_INTERVAL(380),
        .CAS_LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
        .sdc_q(sdc_q), .sdc_done(sdc_done),
        .SDRAM_CKE(SDRAM_CKE), .SDRAM_CSn(SDRAM_CSn), .SDRAM_WEn(SDRAM_WEn),
        .SDRAM_CASn(SDRAM_CASn), .SDRAM_RASn(SDRAM_RASn),
        .SDRAM_A(SDRAM_A), .SDRAM_BA(SDRAM_BA), .SDRAM_DQM(SDRAM_DQM), .SDRAM_DQ(SDRAM_DQ)
    );

    // SDRAM model clocked on ~clk; CL2 read data is driven for one SDRAM clock.
    logic [31:0] mem [logic [23:0]];
    logic [12:0] open_row [4];
    logic [31:0] rd_data, m_dq;
    logic        m_oe = 1'b0;
    int          rd_delay = 0;
    logic [23:0] key;

    assign SDRAM_DQ = m_oe ? m_dq : 'z;

    always @(negedge clk) begin
        if (rd_delay == 1) begin
            m_oe = 1'b1;
            m_dq = rd_data;
        end else begin
            m_oe = 1'b0;
        end
        if (rd_delay > 0) rd_delay--;
        case (cmd)
            C_ACT: open_row[SDRAM_BA] = SDRAM_A;
            C_WR: begin
                key = {open_row[SDRAM_BA], SDRAM_BA, SDRAM_A[8:0]};
                mem[key] = SDRAM_DQ;
            end
            C_RD: begin
                key = {open_row[SDRAM_BA], SDRAM_BA, SDRAM_A[8:0]};
                rd_data = mem.exists(key) ? mem[key] : 32'hBAD0BAD0;
                rd_delay = 2;
            end
            default: ;
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Init sequence capture
    logic [3:0]  ic_cmd [4];
    logic [12:0] ic_a   [4];
    logic [1:0]  ic_ba  [4];
    int          ic_pos [4];
    int          ic_n, ic_dones;

    task automatic collect_init();
        ic_n = 0;
        ic_dones = 0;
        for (int i = 1; i <= 300 && ic_n < 4; i++) begin
            step();
            if (sdc_done) ic_dones++;
            if (SDRAM_CSn == 1'b0 && cmd != C_NOP) begin
                ic_cmd[ic_n] = cmd;
                ic_a[ic_n]   = SDRAM_A;
                ic_ba[ic_n]  = SDRAM_BA;
                ic_pos[ic_n] = i;
                ic_n++;
            end
        end
    endtask

    // Single access observation
    bit          op_timeout;
    int          op_wait, op_done_lat;
    logic [12:0] op_act_a, op_rw_a;
    logic [1:0]  op_act_ba, op_rw_ba;
    logic [3:0]  op_rw_cmd, op_rw_dqm;
    logic [31:0] op_rw_dq, op_q;
    logic        op_done_after;

    task automatic issue_op(input logic we, input logic [23:0] addr, input logic [31:0] data);
        sdc_we = we;
        sdc_addr = addr;
        sdc_data = data;
        sdc_start = 1'b1;
        op_timeout = 1'b1;
        op_wait = -1;
        op_done_lat = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (cmd == C_ACT) begin
                op_timeout = 1'b0;
                op_wait = i + 1;
                break;
            end
        end
        if (!op_timeout) begin
            op_act_a = SDRAM_A;
            op_act_ba = SDRAM_BA;
            for (int c = 1; c <= 12 && op_done_lat < 0; c++) begin
                step();
                if (c == 2) begin
                    op_rw_cmd = cmd;
                    op_rw_a = SDRAM_A;
                    op_rw_ba = SDRAM_BA;
                    op_rw_dqm = SDRAM_DQM;
                    op_rw_dq = SDRAM_DQ;
                end
                if (sdc_done) begin
                    op_done_lat = c;
                    op_q = sdc_q;
                end
            end
            step();
            op_done_after = sdc_done;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        total++; if (SDRAM_CKE !== 1'b1) begin bad++; $display("FAIL rst_cke got=%0h want=1", SDRAM_CKE); end
        total++; if (cmd !== 4'b1111) begin bad++; $display("FAIL rst_cmd got=%0h want=f", cmd); end
        total++; if (SDRAM_A !== 13'h0) begin bad++; $display("FAIL rst_a got=%0h want=0", SDRAM_A); end
        total++; if (SDRAM_BA !== 2'h0) begin bad++; $display("FAIL rst_ba got=%0h want=0", SDRAM_BA); end
        total++; if (SDRAM_DQM !== 4'hF) begin bad++; $display("FAIL rst_dqm got=%0h want=f", SDRAM_DQM); end
        total++; if (sdc_q !== 32'h0) begin bad++; $display("FAIL rst_q got=%0h want=0", sdc_q); end
        total++; if (sdc_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h want=0", sdc_done); end
    endtask

    task automatic test_init();
        reset = 1'b0;
        collect_init();
        total++; if (ic_n !== 4) begin bad++; $display("FAIL init_count got=%0d want=4", ic_n); end
        total++; if (ic_cmd[0] !== C_PRE || ic_a[0][10] !== 1'b1) begin bad++; $display("FAIL init_pre got=%0h/%0h want=2/400", ic_cmd[0], ic_a[0]); end
        total++; if (ic_cmd[1] !== C_REF || ic_cmd[2] !== C_REF) begin bad++; $display("FAIL init_refs got=%0h,%0h want=1,1", ic_cmd[1], ic_cmd[2]); end
        total++; if (ic_cmd[3] !== C_MRS || ic_a[3] !== 13'h020 || ic_ba[3] !== 2'd0) begin bad++; $display("FAIL init_mrs got=%0h/%0h/%0h want=0/20/0", ic_cmd[3], ic_a[3], ic_ba[3]); end
        total++; if (ic_pos[0] < 51) begin bad++; $display("FAIL init_wait got=%0d want>=51", ic_pos[0]); end
        total++; if (ic_pos[1] - ic_pos[0] !== 2) begin bad++; $display("FAIL init_pre_gap got=%0d want=2", ic_pos[1] - ic_pos[0]); end
        total++; if (ic_pos[2] - ic_pos[1] !== 4 || ic_pos[3] - ic_pos[2] !== 4) begin bad++; $display("FAIL init_ref_gap got=%0d,%0d want=4,4", ic_pos[2] - ic_pos[1], ic_pos[3] - ic_pos[2]); end
        step();
        total++; if (cmd !== C_NOP) begin bad++; $display("FAIL init_nop1 got=%0h want=7", cmd); end
        step();
        total++; if (cmd !== C_NOP) begin bad++; $display("FAIL init_nop2 got=%0h want=7", cmd); end
        step();
        total++; if (SDRAM_CSn !== 1'b1 || SDRAM_DQM !== 4'hF) begin bad++; $display("FAIL idle_pins got=%0h/%0h want=1/f", SDRAM_CSn, SDRAM_DQM); end
    endtask

    task automatic test_write();
        int acts = 0;
        int dones = 0;
        issue_op(1'b1, 24'd21, 32'hABCDEF23);
        total++; if (op_timeout) begin bad++; $display("FAIL wr_act got=timeout want=ACT"); end
        total++; if (op_act_a !== 13'd0 || op_act_ba !== 2'd0) begin bad++; $display("FAIL wr_act_addr got=%0h/%0h want=0/0", op_act_a, op_act_ba); end
        total++; if (op_rw_cmd !== C_WR) begin bad++; $display("FAIL wr_cmd got=%0h want=4", op_rw_cmd); end
        total++; if (op_rw_a !== 13'h415 || op_rw_ba !== 2'd0) begin bad++; $display("FAIL wr_col got=%0h/%0h want=415/0", op_rw_a, op_rw_ba); end
        total++; if (op_rw_dq !== 32'hABCDEF23) begin bad++; $display("FAIL wr_dq got=%0h want=abcdef23", op_rw_dq); end
        total++; if (op_rw_dqm !== 4'h0) begin bad++; $display("FAIL wr_dqm got=%0h want=0", op_rw_dqm); end
        total++; if (op_done_lat !== 6) begin bad++; $display("FAIL wr_done_lat got=%0d want=6", op_done_lat); end
        total++; if (op_done_after !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%0h want=0", op_done_after); end
        for (int i = 0; i < 30; i++) begin
            step();
            if (cmd == C_ACT) acts++;
            if (sdc_done) dones++;
        end
        total++; if (acts !== 0 || dones !== 0) begin bad++; $display("FAIL wr_no_repeat got=%0d/%0d want=0/0", acts, dones); end
        sdc_start = 1'b0;
        step();
    endtask

    task automatic test_read();
        issue_op(1'b0, 24'd21, 32'h0);
        total++; if (op_timeout) begin bad++; $display("FAIL rd_act got=timeout want=ACT"); end
        total++; if (op_rw_cmd !== C_RD || op_rw_a !== 13'h415) begin bad++; $display("FAIL rd_cmd got=%0h/%0h want=5/415", op_rw_cmd, op_rw_a); end
        total++; if (op_rw_dqm !== 4'h0) begin bad++; $display("FAIL rd_dqm got=%0h want=0", op_rw_dqm); end
        total++; if (op_done_lat !== 6) begin bad++; $display("FAIL rd_done_lat got=%0d want=6", op_done_lat); end
        total++; if (op_q !== 32'hABCDEF23) begin bad++; $display("FAIL rd_q got=%0h want=abcdef23", op_q); end
        sdc_start = 1'b0;
        repeat (5) step();
        total++; if (sdc_q !== 32'hABCDEF23) begin bad++; $display("FAIL rd_q_hold got=%0h want=abcdef23", sdc_q); end
    endtask

    task automatic test_boundary();
        issue_op(1'b1, 24'hFFFFFF, 32'h12345678);
        total++; if (op_act_a !== 13'h1FFF || op_act_ba !== 2'd3) begin bad++; $display("FAIL bnd_act got=%0h/%0h want=1fff/3", op_act_a, op_act_ba); end
        total++; if (op_rw_cmd !== C_WR || op_rw_a !== 13'h5FF || op_rw_ba !== 2'd3) begin bad++; $display("FAIL bnd_wr got=%0h/%0h/%0h want=4/5ff/3", op_rw_cmd, op_rw_a, op_rw_ba); end
        total++; if (op_rw_dq !== 32'h12345678) begin bad++; $display("FAIL bnd_dq got=%0h want=12345678", op_rw_dq); end
        total++; if (sdc_q !== 32'hABCDEF23) begin bad++; $display("FAIL bnd_q_kept got=%0h want=abcdef23", sdc_q); end
        sdc_start = 1'b0;
        step();
        issue_op(1'b0, 24'hFFFFFF, 32'h0);
        total++; if (op_q !== 32'h12345678 || op_done_lat !== 6) begin bad++; $display("FAIL bnd_rd got=%0h@%0d want=12345678@6", op_q, op_done_lat); end
        sdc_start = 1'b0;
        step();
        issue_op(1'b0, 24'd21, 32'h0);
        total++; if (op_q !== 32'hABCDEF23) begin bad++; $display("FAIL bnd_rd21 got=%0h want=abcdef23", op_q); end
        sdc_start = 1'b0;
        step();
    endtask

`ifdef SDRAM_REFRESH_EN
    task automatic test_refresh();
        int t0 = -1;
        int t1 = -1;
        int gap, nops, lat;
        logic [31:0] q;
        for (int i = 0; i < 900 && t1 < 0; i++) begin
            step();
            if (cmd == C_REF) begin
                if (t0 < 0) t0 = i;
                else t1 = i;
            end
        end
        gap = (t0 >= 0 && t1 >= 0) ? t1 - t0 : -1;
        total++; if (gap !== 380) begin bad++; $display("FAIL ref_interval got=%0d want=380", gap); end
        repeat (379) step();
        sdc_we = 1'b0;
        sdc_addr = 24'd21;
        sdc_start = 1'b1;
        step();
        total++; if (cmd !== C_REF) begin bad++; $display("FAIL ref_first got=%0h want=1", cmd); end
        nops = 0;
        repeat (3) begin
            step();
            if (cmd == C_NOP) nops++;
        end
        total++; if (nops !== 3) begin bad++; $display("FAIL ref_nops got=%0d want=3", nops); end
        step();
        total++; if (cmd !== C_ACT) begin bad++; $display("FAIL ref_then_act got=%0h want=3", cmd); end
        lat = -1;
        q = '0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            step();
            if (sdc_done) begin
                lat = c;
                q = sdc_q;
            end
        end
        total++; if (lat !== 6 || q !== 32'hABCDEF23) begin bad++; $display("FAIL ref_req_rd got=%0h@%0d want=abcdef23@6", q, lat); end
        sdc_start = 1'b0;
        step();
    endtask
`else
    task automatic test_no_refresh();
        int refs = 0;
        for (int i = 0; i < 900; i++) begin
            step();
            if (cmd == C_REF) refs++;
        end
        total++; if (refs !== 0) begin bad++; $display("FAIL no_refresh got=%0d want=0", refs); end
    endtask
`endif

    task automatic test_reset_abort();
        bit found = 1'b0;
        int dones = 0;
        sdc_we = 1'b1;
        sdc_addr = 24'h000100;
        sdc_data = 32'h55AA55AA;
        sdc_start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (cmd == C_ACT) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL abort_act got=timeout want=ACT"); end
        repeat (3) step();
        reset = 1'b1;
        #1;
        total++; if (cmd !== 4'b1111 || SDRAM_CKE !== 1'b1) begin bad++; $display("FAIL abort_cmd got=%0h/%0h want=f/1", cmd, SDRAM_CKE); end
        total++; if (SDRAM_A !== 13'h0 || SDRAM_BA !== 2'h0 || SDRAM_DQM !== 4'hF) begin bad++; $display("FAIL abort_pins got=%0h/%0h/%0h want=0/0/f", SDRAM_A, SDRAM_BA, SDRAM_DQM); end
        total++; if (sdc_q !== 32'h0 || sdc_done !== 1'b0) begin bad++; $display("FAIL abort_outs got=%0h/%0h want=0/0", sdc_q, sdc_done); end
        sdc_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            if (sdc_done) dones++;
        end
        #2;
        reset = 1'b0;
        sdc_we = 1'b0;
        sdc_addr = 24'd21;
        sdc_start = 1'b1;
        collect_init();
        dones += ic_dones;
        total++; if (ic_n !== 4 || ic_cmd[0] !== C_PRE || ic_cmd[1] !== C_REF || ic_cmd[2] !== C_REF || ic_cmd[3] !== C_MRS) begin bad++; $display("FAIL abort_reinit got=%0d cmds want=PRE,REF,REF,MRS", ic_n); end
        total++; if (ic_pos[0] < 51) begin bad++; $display("FAIL abort_wait got=%0d want>=51", ic_pos[0]); end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        issue_op(1'b0, 24'd21, 32'h0);
        total++; if (op_wait !== 3) begin bad++; $display("FAIL pending_act got=%0d want=3", op_wait); end
        total++; if (op_q !== 32'hABCDEF23 || op_done_lat !== 6) begin bad++; $display("FAIL pending_rd got=%0h@%0d want=abcdef23@6", op_q, op_done_lat); end
        sdc_start = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        sdc_start = 1'b0;
        sdc_we = 1'b0;
        sdc_addr = '0;
        sdc_data = '0;
        test_reset();
        test_init();
        test_write();
        test_read();
        test_boundary();
`ifdef SDRAM_REFRESH_EN
        test_refresh();
`else
        test_no_refresh();
`endif
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
